// File: rtl/lut4_inv_seq.sv
// Sequential inverter for a 16-entry 4-bit lookup table (lut4 operand packing).
// Walks one forward entry per cycle, scatters its index into the inverse slot and flags duplicate values.
module lut4_inv_seq (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        valid,
  input  logic [31:0] lut_lo,
  input  logic [31:0] lut_hi,
  output logic        busy,
  output logic        ready,
  output logic [31:0] inv_lo,
  output logic [31:0] inv_hi,
  output logic        perm_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WORK = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [15:0] seen;
  logic [31:0] lo_q;
  logic [31:0] hi_q;

  logic [4:0]  ipos;
  logic [3:0]  v;
  logic [4:0]  vpos;

  // Entry i occupies bit pair 2i in both halves; v is the forward value of entry cnt.
  assign ipos = {cnt, 1'b0};
  assign v    = {hi_q[ipos +: 2], lo_q[ipos +: 2]};
  assign vpos = {v, 1'b0};

  assign busy  = (state != IDLE);
  assign ready = (state == DONE);

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      seen     <= 16'd0;
      lo_q     <= 32'd0;
      hi_q     <= 32'd0;
      inv_lo   <= 32'd0;
      inv_hi   <= 32'd0;
      perm_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (valid) begin
            lo_q     <= lut_lo;
            hi_q     <= lut_hi;
            inv_lo   <= 32'd0;
            inv_hi   <= 32'd0;
            perm_err <= 1'b0;
            seen     <= 16'd0;
            cnt      <= 4'd0;
            state    <= WORK;
          end
        end
        WORK: begin
          // Later indices overwrite earlier ones, so duplicates resolve to the highest i.
          inv_lo[vpos +: 2] <= cnt[1:0];
          inv_hi[vpos +: 2] <= cnt[3:2];
          seen[v]           <= 1'b1;
          if (seen[v]) perm_err <= 1'b1;
          cnt <= cnt + 4'd1;
          if (cnt == 4'hF) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lut4_inv_seq.sv
// Directed bench for lut4_inv_seq: hand-computed inverse tables, latency, reset and back-to-back behaviour.
module tb_lut4_inv_seq;

  logic        g_clk;
  logic        g_resetn;
  logic        valid;
  logic [31:0] lut_lo;
  logic [31:0] lut_hi;
  logic        busy;
  logic        ready;
  logic [31:0] inv_lo;
  logic [31:0] inv_hi;
  logic        perm_err;

  int n_cmp;
  int n_err;

  // Identity table and PRESENT S-box (C56B90AD3EF84712) with its inverse (5EF8C12DB463079A).
  localparam logic [31:0] ID_LO  = 32'hE4E4E4E4;
  localparam logic [31:0] ID_HI  = 32'hFFAA5500;
  localparam logic [31:0] PR_LO  = 32'h9C3B61E4;
  localparam logic [31:0] PR_HI  = 32'h05BCE297;
  localparam logic [31:0] PRI_LO = 32'h9CE36439;
  localparam logic [31:0] PRI_HI = 32'hA416C3BD;

  lut4_inv_seq dut (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .valid    (valid),
    .lut_lo   (lut_lo),
    .lut_hi   (lut_hi),
    .busy     (busy),
    .ready    (ready),
    .inv_lo   (inv_lo),
    .inv_hi   (inv_hi),
    .perm_err (perm_err)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  task automatic tick;
    @(posedge g_clk);
    #1;
  endtask

  task automatic test_reset;
    g_resetn = 1'b0;
    valid    = 1'b1;
    lut_lo   = ID_LO;
    lut_hi   = ID_HI;
    tick();
    tick();
    n_cmp++;
    if ({busy, ready, perm_err} !== 3'b000 || inv_lo !== 32'd0 || inv_hi !== 32'd0) begin
      n_err++;
      $display("FAIL reset_state: busy=%b ready=%b perm=%b inv_lo=%h inv_hi=%h, want all 0",
               busy, ready, perm_err, inv_lo, inv_hi);
    end
    valid    = 1'b0;
    g_resetn = 1'b1;
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: busy=%b want 0", busy);
    end
  endtask

  // One request with valid dropped after accept; checks latency, result, pulse width and hold.
  task automatic run_table(input string name, input logic [31:0] lo, input logic [31:0] hi,
                           input logic [31:0] elo, input logic [31:0] ehi, input logic eperm);
    int cyc;
    valid  = 1'b1;
    lut_lo = lo;
    lut_hi = hi;
    tick();
    valid  = 1'b0;
    lut_lo = ~lo;
    lut_hi = ~hi;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL %s_busy_after_accept: busy=%b want 1", name, busy);
    end
    cyc = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      cyc++;
      if (ready === 1'b1) break;
    end
    n_cmp++;
    if (cyc !== 16 || ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s_latency: ready seen after %0d edges (ready=%b), want 16", name, cyc, ready);
    end
    n_cmp++;
    if (inv_lo !== elo || inv_hi !== ehi || perm_err !== eperm) begin
      n_err++;
      $display("FAIL %s_result: inv_lo=%h inv_hi=%h perm=%b, want %h %h %b",
               name, inv_lo, inv_hi, perm_err, elo, ehi, eperm);
    end
    tick();
    tick();
    n_cmp++;
    if (ready !== 1'b0 || busy !== 1'b0 || inv_lo !== elo || inv_hi !== ehi || perm_err !== eperm) begin
      n_err++;
      $display("FAIL %s_hold: ready=%b busy=%b inv_lo=%h inv_hi=%h perm=%b, want 0 0 %h %h %b",
               name, ready, busy, inv_lo, inv_hi, perm_err, elo, ehi, eperm);
    end
  endtask

  task automatic test_identity;
    run_table("identity", ID_LO, ID_HI, ID_LO, ID_HI, 1'b0);
  endtask

  task automatic test_present;
    run_table("present", PR_LO, PR_HI, PRI_LO, PRI_HI, 1'b0);
  endtask

  // All entries map to 0: last writer (i=15) lands in slot 0, every other slot stays 0.
  task automatic test_all_zero;
    run_table("all_zero", 32'd0, 32'd0, 32'h00000003, 32'h00000003, 1'b1);
  endtask

  task automatic test_valid_ignored;
    int bcnt;
    int pulses;
    logic [31:0] rlo, rhi;
    logic rperm;
    valid  = 1'b1;
    lut_lo = ID_LO;
    lut_hi = ID_HI;
    tick();
    bcnt   = 0;
    pulses = 0;
    rlo    = 32'hDEADBEEF;
    rhi    = 32'hDEADBEEF;
    rperm  = 1'bx;
    for (int c = 0; c < 40; c++) begin
      if (busy !== 1'b1) break;
      bcnt++;
      if (ready === 1'b1) begin
        pulses++;
        rlo   = inv_lo;
        rhi   = inv_hi;
        rperm = perm_err;
        valid = 1'b0;
      end else begin
        valid  = ~valid;
        lut_lo = (c % 2 == 0) ? 32'd0 : 32'h12345678;
        lut_hi = (c % 2 == 0) ? 32'd0 : 32'h9ABCDEF0;
      end
      tick();
    end
    valid = 1'b0;
    n_cmp++;
    if (bcnt !== 17 || pulses !== 1) begin
      n_err++;
      $display("FAIL toggle_busy_len: busy cycles=%0d ready pulses=%0d, want 17 and 1", bcnt, pulses);
    end
    n_cmp++;
    if (rlo !== ID_LO || rhi !== ID_HI || rperm !== 1'b0) begin
      n_err++;
      $display("FAIL toggle_result: inv_lo=%h inv_hi=%h perm=%b, want %h %h 0", rlo, rhi, rperm, ID_LO, ID_HI);
    end
    tick();
  endtask

  task automatic test_reset_mid;
    int seen_ready;
    valid  = 1'b1;
    lut_lo = PR_LO;
    lut_hi = PR_HI;
    tick();
    valid = 1'b0;
    repeat (7) tick();
    n_cmp++;
    if (busy !== 1'b1 || inv_lo === 32'd0) begin
      n_err++;
      $display("FAIL midwork_progress: busy=%b inv_lo=%h, want busy 1 and partial nonzero inverse", busy, inv_lo);
    end
    g_resetn = 1'b0;
    tick();
    g_resetn = 1'b1;
    n_cmp++;
    if ({busy, ready, perm_err} !== 3'b000 || inv_lo !== 32'd0 || inv_hi !== 32'd0) begin
      n_err++;
      $display("FAIL midwork_reset: busy=%b ready=%b perm=%b inv_lo=%h inv_hi=%h, want all 0",
               busy, ready, perm_err, inv_lo, inv_hi);
    end
    seen_ready = 0;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (ready === 1'b1 || busy === 1'b1) seen_ready++;
    end
    n_cmp++;
    if (seen_ready !== 0) begin
      n_err++;
      $display("FAIL midwork_no_ready: %0d cycles with ready/busy after abort, want 0", seen_ready);
    end
    run_table("after_abort", PR_LO, PR_HI, PRI_LO, PRI_HI, 1'b0);
  endtask

  task automatic test_back_to_back;
    int t1, t2, npulse;
    logic [31:0] lo1, hi1, lo2, hi2;
    valid  = 1'b1;
    lut_lo = ID_LO;
    lut_hi = ID_HI;
    tick();
    lut_lo = PR_LO;
    lut_hi = PR_HI;
    t1 = -1;
    t2 = -1;
    npulse = 0;
    lo1 = 32'd0; hi1 = 32'd0; lo2 = 32'd0; hi2 = 32'd0;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (ready === 1'b1) begin
        npulse++;
        if (npulse == 1) begin
          t1 = c; lo1 = inv_lo; hi1 = inv_hi;
        end else if (npulse == 2) begin
          t2 = c; lo2 = inv_lo; hi2 = inv_hi;
          valid = 1'b0;
        end
      end
      if (npulse >= 2) break;
    end
    valid = 1'b0;
    n_cmp++;
    if (t1 !== 16 || t2 - t1 !== 18) begin
      n_err++;
      $display("FAIL b2b_timing: pulses at %0d and %0d, want 16 and 34", t1, t2);
    end
    n_cmp++;
    if (lo1 !== ID_LO || hi1 !== ID_HI) begin
      n_err++;
      $display("FAIL b2b_first: inv_lo=%h inv_hi=%h, want %h %h", lo1, hi1, ID_LO, ID_HI);
    end
    n_cmp++;
    if (lo2 !== PRI_LO || hi2 !== PRI_HI) begin
      n_err++;
      $display("FAIL b2b_second: inv_lo=%h inv_hi=%h, want %h %h", lo2, hi2, PRI_LO, PRI_HI);
    end
    tick();
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_idle: busy=%b want 0", busy);
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    g_resetn = 1'b0;
    valid    = 1'b0;
    lut_lo   = 32'd0;
    lut_hi   = 32'd0;
    test_reset();
    test_identity();
    test_present();
    test_all_zero();
    test_valid_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
